// File: rtl/cpu_pkg.sv
// Shared encodings for the hardwired controller: opcodes, IR fields,
// FSM states and a small opcode classifier.
package cpu_pkg;

  localparam int NUM_REGS = 16;
  localparam int OP_W     = 5;

  localparam int IR_OP_MSB = 31;
  localparam int IR_OP_LSB = 27;
  localparam int IR_RA_MSB = 26;
  localparam int IR_RA_LSB = 23;
  localparam int IR_RB_MSB = 22;
  localparam int IR_RB_LSB = 19;
  localparam int IR_RC_MSB = 18;
  localparam int IR_RC_LSB = 15;

  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_ALU3, CLS_MULDIV, CLS_UNARY, CLS_HALT
  } op_class_t;

  // nop and every undefined opcode fall into CLS_NONE
  function automatic op_class_t op_class(input logic [OP_W-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL: return CLS_ALU3;
      OP_MUL, OP_DIV:                  return CLS_MULDIV;
      OP_NEG, OP_NOT:                  return CLS_UNARY;
      OP_HALT:                         return CLS_HALT;
      default:                         return CLS_NONE;
    endcase
  endfunction

endpackage

// File: rtl/reg_select.sv
// One-hot GPR select: picks Ra/Rb/Rc from IR and turns it
// into load (reg_in) and drive (reg_out) enables.
module reg_select
  import cpu_pkg::*;
#(
  parameter int REG_COUNT = NUM_REGS
) (
  input  logic [31:0]          IR,
  input  logic                 gra,
  input  logic                 grb,
  input  logic                 grc,
  input  logic                 rin,
  input  logic                 rout,
  output logic [REG_COUNT-1:0] reg_in,
  output logic [REG_COUNT-1:0] reg_out
);

  logic [3:0]           sel;
  logic [REG_COUNT-1:0] onehot;
  logic                 unused_ir;

  assign unused_ir = ^{IR[IR_OP_MSB:IR_OP_LSB], IR[IR_RC_LSB-1:0]};

  always_comb begin
    sel = '0;
    unique case (1'b1)
      gra:     sel = IR[IR_RA_MSB:IR_RA_LSB];
      grb:     sel = IR[IR_RB_MSB:IR_RB_LSB];
      grc:     sel = IR[IR_RC_MSB:IR_RC_LSB];
      default: sel = '0;
    endcase
  end

  assign onehot  = REG_COUNT'(1) << sel;
  assign reg_in  = rin  ? onehot : '0;
  assign reg_out = rout ? onehot : '0;

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore controller for fetch and register-register execute.
// Strobes are a decode of the state register (and IR), so reset clears them at once.
module control_unit
  import cpu_pkg::*;
#(
  parameter int REG_COUNT = NUM_REGS,
  parameter int OPCODE_W  = OP_W
) (
  input  logic                 Clock,
  input  logic                 Clear_n,
  input  logic [31:0]          IR,
  input  logic                 Stop,
  output logic                 Run,
  output logic [REG_COUNT-1:0] reg_in,
  output logic [REG_COUNT-1:0] reg_out,
  output logic                 PCout,
  output logic                 Zhighout,
  output logic                 Zlowout,
  output logic                 MDRout,
  output logic                 HIout,
  output logic                 LOout,
  output logic                 PCin,
  output logic                 MARin,
  output logic                 MDRin,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 IncPC,
  output logic                 Read,
  output logic [OPCODE_W-1:0]  opcode
);

  state_t          state;
  state_t          state_nxt;
  state_t          fin;
  logic            stop_flag;
  logic [OP_W-1:0] op;
  op_class_t       cls;
  logic            is_alu3;
  logic            is_muldiv;
  logic            is_unary;
  logic            is_halt;
  logic            gra, grb, grc, rin, rout;
  logic [OP_W-1:0] alu_op;

  assign op        = IR[IR_OP_MSB:IR_OP_LSB];
  assign cls       = op_class(op);
  assign is_alu3   = (cls == CLS_ALU3);
  assign is_muldiv = (cls == CLS_MULDIV);
  assign is_unary  = (cls == CLS_UNARY);
  assign is_halt   = (cls == CLS_HALT);

  // a pending Stop turns the instruction boundary into HALT
  assign fin = stop_flag ? HALT : T0;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RESET: state_nxt = T0;
      T0:    state_nxt = T1;
      T1:    state_nxt = T2;
      T2: begin
        unique case (1'b1)
          is_halt:                        state_nxt = HALT;
          is_alu3 || is_muldiv || is_unary: state_nxt = T3;
          default:                        state_nxt = fin;
        endcase
      end
      T3:    state_nxt = T4;
      T4:    state_nxt = is_unary ? fin : T5;
      T5:    state_nxt = is_muldiv ? T6 : fin;
      T6:    state_nxt = fin;
      HALT:  state_nxt = HALT;
      default: state_nxt = RESET;
    endcase
  end

  always_ff @(posedge Clock or negedge Clear_n) begin
    if (!Clear_n) begin
      state     <= RESET;
      stop_flag <= 1'b0;
    end else begin
      state     <= state_nxt;
      stop_flag <= stop_flag | Stop;
    end
  end

  always_comb begin
    {PCout, Zhighout, Zlowout, MDRout, HIout, LOout} = '0;
    {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin} = '0;
    {IncPC, Read, gra, grb, grc, rin, rout}          = '0;
    alu_op = '0;
    Run    = (state != RESET) && (state != HALT);
    unique case (state)
      T0: begin
        PCout = 1'b1; MARin = 1'b1;
        IncPC = 1'b1; PCin  = 1'b1;
      end
      T1: begin
        Read = 1'b1; MDRin = 1'b1;
      end
      T2: begin
        MDRout = 1'b1; IRin = 1'b1;
      end
      T3: begin
        unique case (1'b1)
          is_muldiv: begin
            gra = 1'b1; rout = 1'b1; Yin = 1'b1;
          end
          is_unary: begin
            grb = 1'b1; rout = 1'b1;
            alu_op = op; Zin = 1'b1;
          end
          is_alu3: begin
            grb = 1'b1; rout = 1'b1; Yin = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        unique case (1'b1)
          is_unary: begin
            Zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
          end
          is_muldiv: begin
            grb = 1'b1; rout = 1'b1;
            alu_op = op; Zin = 1'b1;
          end
          is_alu3: begin
            grc = 1'b1; rout = 1'b1;
            alu_op = op; Zin = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        Zlowout = 1'b1;
        unique case (1'b1)
          is_muldiv: LOin = 1'b1;
          is_alu3: begin
            gra = 1'b1; rin = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

  assign opcode = OPCODE_W'(alu_op);

  reg_select #(
    .REG_COUNT(REG_COUNT)
  ) u_reg_select (
    .IR      (IR),
    .gra     (gra),
    .grb     (grb),
    .grc     (grc),
    .rin     (rin),
    .rout    (rout),
    .reg_in  (reg_in),
    .reg_out (reg_out)
  );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: instruction table, directed corner sequences
// and a random run against a step-count model of the instruction timing.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear_n = 1'b0;
  logic [31:0] IR = '0;
  logic        Stop = 1'b0;
  logic        Run;
  logic [15:0] reg_in, reg_out;
  logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout;
  logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic        IncPC, Read;
  logic [4:0]  opcode;

  control_unit dut (
    .Clock(Clock), .Clear_n(Clear_n), .IR(IR), .Stop(Stop), .Run(Run),
    .reg_in(reg_in), .reg_out(reg_out),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .MDRout(MDRout), .HIout(HIout), .LOout(LOout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .Zin(Zin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .opcode(opcode)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        run;
    logic [15:0] rin;
    logic [15:0] rout;
    logic        pco, zho, zlo, mdro, hio, loo;
    logic        pci, mari, mdri, iri, yi, zi, hii, loi;
    logic        inc, rd;
    logic [4:0]  opc;
  } outs_t;

  outs_t dut_o;
  assign dut_o = {Run, reg_in, reg_out,
                  PCout, Zhighout, Zlowout, MDRout, HIout, LOout,
                  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
                  IncPC, Read, opcode};

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // model: position within the current instruction, counted in cycles
  bit m_reset = 1'b1;
  bit m_halt  = 1'b0;
  bit m_flag  = 1'b0;
  int m_step  = 0;

  function automatic int exec_len(input logic [4:0] op);
    if (op >= 5'd3 && op <= 5'd11) return 3;
    if (op == 5'd15 || op == 5'd16) return 4;
    if (op == 5'd17 || op == 5'd18) return 2;
    return 0;
  endfunction

  function automatic void model_adv();
    logic [4:0] op;
    op = IR[31:27];
    if (!Clear_n) begin
      m_reset = 1; m_halt = 0; m_flag = 0; m_step = 0;
      return;
    end
    if (m_reset) begin
      m_reset = 0; m_step = 0;
    end else if (!m_halt) begin
      if (m_step == 2 && op == 5'd27) m_halt = 1;
      else if (m_step + 1 == 3 + exec_len(op)) begin
        if (m_flag) m_halt = 1;
        else m_step = 0;
      end else m_step++;
    end
    if (Stop) m_flag = 1;
  endfunction

  function automatic outs_t model_exp();
    outs_t e;
    logic [4:0] op;
    logic [15:0] ra, rb, rc;
    int x;
    e  = '0;
    op = IR[31:27];
    ra = 16'h1 << IR[26:23];
    rb = 16'h1 << IR[22:19];
    rc = 16'h1 << IR[18:15];
    if (m_reset || m_halt) return e;
    e.run = 1;
    x = m_step - 3;
    if (m_step == 0) begin
      e.pco = 1; e.mari = 1; e.inc = 1; e.pci = 1;
    end else if (m_step == 1) begin
      e.rd = 1; e.mdri = 1;
    end else if (m_step == 2) begin
      e.mdro = 1; e.iri = 1;
    end else if (exec_len(op) == 3) begin
      if (x == 0) begin e.rout = rb; e.yi = 1; end
      if (x == 1) begin e.rout = rc; e.zi = 1; e.opc = op; end
      if (x == 2) begin e.zlo = 1; e.rin = ra; end
    end else if (exec_len(op) == 4) begin
      if (x == 0) begin e.rout = ra; e.yi = 1; end
      if (x == 1) begin e.rout = rb; e.zi = 1; e.opc = op; end
      if (x == 2) begin e.zlo = 1; e.loi = 1; end
      if (x == 3) begin e.zho = 1; e.hii = 1; end
    end else if (exec_len(op) == 2) begin
      if (x == 0) begin e.rout = rb; e.zi = 1; e.opc = op; end
      if (x == 1) begin e.zlo = 1; e.rin = ra; end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_adv();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Clear_n = 1'b0;
    Stop    = 1'b0;
    m_reset = 1; m_halt = 0; m_flag = 0; m_step = 0;
    tick();
    Clear_n = 1'b1;
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input int a,
                                     input int b, input int c);
    return {op, 4'(a), 4'(b), 4'(c), 15'd0};
  endfunction

  typedef struct {
    logic [31:0] ir;
    int          len;
    logic [4:0]  zop;
    bit          halts;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n, bad;
    logic [4:0] zop, rop;
    vecs[0]  = '{32'h18918000, 6, 5'h03, 0};
    vecs[1]  = '{32'h30918000, 6, 5'h06, 0};
    vecs[2]  = '{mk(5'h04, 5, 6, 7), 6, 5'h04, 0};
    vecs[3]  = '{mk(5'h0B, 15, 0, 9), 6, 5'h0B, 0};
    vecs[4]  = '{32'h79180000, 7, 5'h0F, 0};
    vecs[5]  = '{mk(5'h10, 4, 4, 0), 7, 5'h10, 0};
    vecs[6]  = '{mk(5'h11, 7, 8, 0), 5, 5'h11, 0};
    vecs[7]  = '{mk(5'h12, 0, 15, 0), 5, 5'h12, 0};
    vecs[8]  = '{32'hD0000000, 3, 5'h00, 0};
    vecs[9]  = '{mk(5'h00, 1, 2, 3), 3, 5'h00, 0};
    vecs[10] = '{mk(5'h1F, 1, 2, 3), 3, 5'h00, 0};
    vecs[11] = '{32'hD8000000, 3, 5'h00, 1};

    @(negedge Clock);
    do_reset();
    chk("reset_state", dut_o, '0);

    // add R1,R2,R3 cycle by cycle
    IR = 32'h18918000;
    tick();
    chk("add_t0", {PCout, MARin, IncPC, PCin, Run}, 5'h1F);
    tick();
    chk("add_t1", {Read, MDRin}, 2'b11);
    tick();
    chk("add_t2", {MDRout, IRin, Read}, 3'b110);
    tick();
    chk("add_t3", {reg_out, Yin, Zin}, {16'h0004, 2'b10});
    tick();
    chk("add_t4", {reg_out, Zin, opcode}, {16'h0008, 1'b1, 5'h03});
    tick();
    chk("add_t5", {Zlowout, reg_in, reg_out, opcode},
        {1'b1, 16'h0002, 16'h0000, 5'h00});
    tick();
    chk("add_next_t0", {PCout, MARin, IncPC, PCin}, 4'hF);

    // mul R2,R3
    do_reset();
    IR = 32'h79180000;
    repeat (4) tick();
    chk("mul_t3", {reg_out, Yin}, {16'h0004, 1'b1});
    tick();
    chk("mul_t4", {reg_out, Zin, opcode}, {16'h0008, 1'b1, 5'h0F});
    tick();
    chk("mul_t5", {Zlowout, LOin, reg_in}, {2'b11, 16'h0});
    tick();
    chk("mul_t6", {Zhighout, HIin, Zlowout}, 3'b110);
    tick();
    chk("mul_next_t0", {PCout, Run}, 2'b11);

    // instruction table: length, Zin-cycle opcode, halting
    foreach (vecs[i]) begin
      do_reset();
      IR = vecs[i].ir;
      tick();
      n = 99; zop = '0; bad = 0;
      for (int c = 0; c < 20; c++) begin
        if (c > 0 && (PCout || !Run)) begin
          n = c;
          break;
        end
        if (Zin) zop = opcode;
        else if (opcode != 5'd0) bad++;
        if ($countones({PCout, Zhighout, Zlowout, MDRout, HIout, LOout}) > 1)
          bad++;
        if (Read && c != 1) bad++;
        if ($countones(reg_in) > 1 || $countones(reg_out) > 1) bad++;
        tick();
      end
      chk($sformatf("vec%0d_len", i), 64'(n), 64'(vecs[i].len));
      chk($sformatf("vec%0d_op", i), 64'(zop), 64'(vecs[i].zop));
      chk($sformatf("vec%0d_run", i), 64'(Run), 64'(!vecs[i].halts));
      chk($sformatf("vec%0d_rules", i), 64'(bad), 64'd0);
    end

    // halt holds until Clear_n
    do_reset();
    IR = 32'hD8000000;
    repeat (4) tick();
    for (int k = 0; k < 10; k++) begin
      chk("halt_hold", dut_o, '0);
      tick();
    end

    // Stop pulse during T1 lets the add finish, then halts
    do_reset();
    IR = 32'h18918000;
    tick();
    tick();
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    repeat (3) tick();
    chk("stop_t5", {Run, Zlowout, reg_in}, {2'b11, 16'h0002});
    tick();
    chk("stop_halt", dut_o, '0);
    tick();
    chk("stop_halt_hold", 64'(Run), 64'd0);

    // Clear_n mid-T4 clears strobes without a clock edge
    do_reset();
    IR = 32'h18918000;
    repeat (5) tick();
    chk("clr_t4", {Zin, opcode}, {1'b1, 5'h03});
    #2 Clear_n = 1'b0;
    #1 chk("clr_async", dut_o, '0);
    tick();
    Clear_n = 1'b1;
    m_reset = 1; m_halt = 0; m_flag = 0; m_step = 0;
    chk("clr_reset", dut_o, '0);
    tick();
    chk("clr_t0", {PCout, MARin, IncPC, PCin, Run}, 5'h1F);

    // random instruction stream against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      chk("rand", dut_o, model_exp());
      Stop = ($urandom_range(0, 99) < 2);
      if (m_halt && $urandom_range(0, 3) == 0) begin
        do_reset();
        continue;
      end
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
        continue;
      end
      if (!m_reset && !m_halt && m_step == 0) begin
        case ($urandom_range(0, 19))
          0, 1, 2, 3, 4, 5, 6, 7, 8: rop = 5'($urandom_range(3, 11));
          9, 10:  rop = 5'($urandom_range(15, 16));
          11, 12: rop = 5'($urandom_range(17, 18));
          13:     rop = 5'h1A;
          14:     rop = 5'h1B;
          default: rop = 5'($urandom);
        endcase
        IR = {rop, 27'($urandom)};
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
